// File: rtl/ppr_walk_engine.sv
// Personalized-PageRank walk engine: M_RW walks of MAX_STEPS hops per seed, bumping a visit counter per (node, seed, step).
// Step costs 11 cycles (6 on restart/dangling); single-port BRAM, read data one cycle after address, no backpressure.
module ppr_walk_engine #(
    parameter int          ADDR_WIDTH   = 13,
    parameter int          DATA_WIDTH   = 32,
    parameter int          SEED_NUM     = 10,
    parameter int          M_RW         = 100,
    parameter int          MAX_STEPS    = 6,
    parameter int          NEI_ADDR_OFF = 10,
    parameter int          CNT_OFF      = 1000,
    parameter logic [15:0] RESTART_THR  = 16'h0000,
    parameter logic [31:0] LFSR_INIT    = 32'h00000007
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);
    localparam int AW = ADDR_WIDTH;
    localparam int DW = DATA_WIDTH;
    localparam int SW = (SEED_NUM  > 1) ? $clog2(SEED_NUM)  : 1;
    localparam int WW = (M_RW      > 1) ? $clog2(M_RW)      : 1;
    localparam int TW = (MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1;

    typedef enum logic [3:0] {
        IDLE, RD_SEED, RD_FIRST, RD_LAST, CHK, RD_NEI, RD_CNT, WR_CNT, ADV, DONE
    } state_t;

    state_t        r_state, w_state_nxt;
    logic          r_ph, w_ph_nxt;
    logic [SW-1:0] r_seed_idx;
    logic [WW-1:0] r_walk_idx;
    logic [TW-1:0] r_step_idx;
    logic [DW-1:0] r_seed_node, r_curr, r_first, r_last, r_cnt;
    logic [AW-1:0] r_nei_addr;
    logic [31:0]   r_lfsr;

    logic          w_restart, w_dangling, w_jump;
    logic          w_last_step, w_last_walk, w_last_seed;
    logic [DW-1:0] w_span, w_rnd, w_nei_off;
    logic [AW-1:0] w_tbl_addr, w_cnt_addr;
    logic [31:0]   w_lfsr_nxt;

    // Borrow out of the 17-bit difference is the unsigned "lfsr_hi < threshold" flag.
    assign w_restart   = 1'(({1'b0, r_lfsr[31:16]} - {1'b0, RESTART_THR}) >> 16);
    assign w_dangling  = r_last < r_first;
    assign w_jump      = w_restart || w_dangling;
    assign w_span      = r_last - r_first + DW'(1);
    assign w_rnd       = DW'(r_lfsr);
    assign w_nei_off   = (w_span == '0) ? w_rnd : (w_rnd % w_span);
    assign w_tbl_addr  = AW'(NEI_ADDR_OFF) + (AW'(r_curr) << 1);
    assign w_cnt_addr  = AW'(CNT_OFF)
                       + (AW'(r_curr) * AW'(SEED_NUM) + AW'(r_seed_idx)) * AW'(MAX_STEPS)
                       + AW'(r_step_idx);
    assign w_last_step = r_step_idx == TW'(MAX_STEPS - 1);
    assign w_last_walk = r_walk_idx == WW'(M_RW - 1);
    assign w_last_seed = r_seed_idx == SW'(SEED_NUM - 1);
    assign w_lfsr_nxt  = {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? 32'h80200003 : 32'h0);

    assign busy = (r_state != IDLE) && (r_state != DONE);
    assign done = r_state == DONE;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state <= IDLE;
            r_ph    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ph    <= w_ph_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ph_nxt    = 1'b0;
        mem_addr    = '0;
        mem_we      = 1'b0;
        mem_wdata   = '0;
        case (r_state)
            IDLE:     if (start) w_state_nxt = RD_SEED;
            RD_SEED: begin
                mem_addr = AW'(r_seed_idx);
                w_ph_nxt = ~r_ph;
                if (r_ph) w_state_nxt = RD_FIRST;
            end
            RD_FIRST: begin
                mem_addr = w_tbl_addr;
                w_ph_nxt = ~r_ph;
                if (r_ph) w_state_nxt = RD_LAST;
            end
            RD_LAST: begin
                mem_addr = w_tbl_addr + AW'(1);
                w_ph_nxt = ~r_ph;
                if (r_ph) w_state_nxt = CHK;
            end
            CHK:      w_state_nxt = w_jump ? ADV : RD_NEI;
            RD_NEI: begin
                mem_addr = r_nei_addr;
                w_ph_nxt = ~r_ph;
                if (r_ph) w_state_nxt = RD_CNT;
            end
            RD_CNT: begin
                mem_addr = w_cnt_addr;
                w_ph_nxt = ~r_ph;
                if (r_ph) w_state_nxt = WR_CNT;
            end
            WR_CNT: begin
                mem_addr    = w_cnt_addr;
                mem_we      = 1'b1;
                mem_wdata   = (&r_cnt) ? r_cnt : r_cnt + DW'(1);
                w_state_nxt = ADV;
            end
            ADV: begin
                if (!w_last_step || !w_last_walk) w_state_nxt = RD_FIRST;
                else if (!w_last_seed)            w_state_nxt = RD_SEED;
                else                              w_state_nxt = DONE;
            end
            DONE:     w_state_nxt = IDLE;
            default:  w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_seed_idx  <= '0;
            r_walk_idx  <= '0;
            r_step_idx  <= '0;
            r_seed_node <= '0;
            r_curr      <= '0;
            r_first     <= '0;
            r_last      <= '0;
            r_cnt       <= '0;
            r_nei_addr  <= '0;
            r_lfsr      <= LFSR_INIT;
        end else begin
            r_lfsr <= w_lfsr_nxt;
            case (r_state)
                IDLE: if (start) begin
                    r_seed_idx <= '0;
                    r_walk_idx <= '0;
                    r_step_idx <= '0;
                end
                RD_SEED: if (r_ph) begin
                    r_seed_node <= mem_rdata;
                    r_curr      <= mem_rdata;
                end
                RD_FIRST: if (r_ph) r_first <= mem_rdata;
                RD_LAST:  if (r_ph) r_last  <= mem_rdata;
                CHK: begin
                    if (w_jump) r_curr     <= r_seed_node;
                    else        r_nei_addr <= AW'(r_first + w_nei_off);
                end
                RD_NEI:   if (r_ph) r_curr <= mem_rdata;
                RD_CNT:   if (r_ph) r_cnt  <= mem_rdata;
                ADV: begin
                    if (!w_last_step) begin
                        r_step_idx <= r_step_idx + 1'b1;
                    end else if (!w_last_walk) begin
                        r_walk_idx <= r_walk_idx + 1'b1;
                        r_step_idx <= '0;
                        r_curr     <= r_seed_node;
                    end else if (!w_last_seed) begin
                        r_seed_idx <= r_seed_idx + 1'b1;
                        r_walk_idx <= '0;
                        r_step_idx <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ppr_walk_engine.sv
// Three engine instances (line graph, dangling seed, forced restart) each backed by a 1-cycle-latency BRAM model.
module tb_ppr_walk_engine;
    logic        clk    = 1'b0;
    logic        arst_n = 1'b0;
    logic        m_start [3];
    logic        m_busy  [3];
    logic        m_done  [3];
    logic [12:0] m_addr  [3];
    logic        m_we    [3];
    logic [31:0] m_wd    [3];
    logic [31:0] m_rd    [3];
    logic [31:0] mem     [3][8192];
    int          n_wr    [3];
    int          n_bad   [3];
    int          n_done  [3];

    logic        pk_clr = 1'b0;
    logic        pk_we  = 1'b0;
    int          pk_sel = 0;
    logic [12:0] pk_addr = '0;
    logic [31:0] pk_dat  = '0;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        int          ph;
        int          addr;
        logic [31:0] exp;
    } vec_t;
    localparam int NV = 16;
    vec_t tbl [NV];

    always #5 clk = ~clk;

    ppr_walk_engine #(.SEED_NUM(1), .M_RW(1), .MAX_STEPS(3), .RESTART_THR(16'h0000)) dut_a (
        .clk(clk), .arst_n(arst_n), .start(m_start[0]), .busy(m_busy[0]), .done(m_done[0]),
        .mem_addr(m_addr[0]), .mem_we(m_we[0]), .mem_wdata(m_wd[0]), .mem_rdata(m_rd[0]));
    ppr_walk_engine #(.SEED_NUM(1), .M_RW(4), .MAX_STEPS(3), .RESTART_THR(16'h0000)) dut_b (
        .clk(clk), .arst_n(arst_n), .start(m_start[1]), .busy(m_busy[1]), .done(m_done[1]),
        .mem_addr(m_addr[1]), .mem_we(m_we[1]), .mem_wdata(m_wd[1]), .mem_rdata(m_rd[1]));
    ppr_walk_engine #(.SEED_NUM(2), .M_RW(2), .MAX_STEPS(3), .RESTART_THR(16'hFFFF)) dut_c (
        .clk(clk), .arst_n(arst_n), .start(m_start[2]), .busy(m_busy[2]), .done(m_done[2]),
        .mem_addr(m_addr[2]), .mem_we(m_we[2]), .mem_wdata(m_wd[2]), .mem_rdata(m_rd[2]));

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (pk_clr) begin
                for (int j = 0; j < 8192; j++) mem[k][j] <= '0;
            end else begin
                m_rd[k] <= mem[k][m_addr[k]];
                if (m_we[k]) begin
                    mem[k][m_addr[k]] <= m_wd[k];
                    n_wr[k] <= n_wr[k] + 1;
                end
                if (pk_we && pk_sel == k) mem[k][pk_addr] <= pk_dat;
            end
            if (!m_we[k] && m_wd[k] != '0) n_bad[k] <= n_bad[k] + 1;
            if (m_done[k]) n_done[k] <= n_done[k] + 1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic poke(input int sel, input int addr, input logic [31:0] dat);
        @(negedge clk);
        pk_sel  = sel;
        pk_addr = 13'(addr);
        pk_dat  = dat;
        pk_we   = 1'b1;
        @(negedge clk);
        pk_we   = 1'b0;
    endtask

    task automatic run(input int sel, input int extra_start_at, output int cyc, output int busy_lo);
        cyc     = 0;
        busy_lo = 0;
        @(negedge clk);
        m_start[sel] = 1'b1;
        @(negedge clk);
        m_start[sel] = 1'b0;
        cyc = 1;
        while (m_done[sel] !== 1'b1 && cyc < 1000) begin
            if (m_busy[sel] !== 1'b1) busy_lo++;
            @(negedge clk);
            cyc++;
            m_start[sel] = (cyc == extra_start_at);
        end
        m_start[sel] = 1'b0;
    endtask

    task automatic check_tbl(input int ph);
        for (int i = 0; i < NV; i++)
            if (tbl[i].ph == ph)
                check($sformatf("p%0d_cnt[%0d]", ph, tbl[i].addr), 64'(mem[0][tbl[i].addr]), 64'(tbl[i].exp));
    endtask

    task automatic clear_counters();
        poke(0, 1004, 32'd0);
        poke(0, 1006, 32'd0);
        poke(0, 1008, 32'd0);
    endtask

    initial begin
        int cyc, blo, w0, d0, hi;
        // Counter address = 1000 + node*3 + step for dut_a (one seed, three steps).
        tbl[0]  = '{1, 1006, 32'd1};  tbl[1]  = '{1, 1004, 32'd1};  tbl[2]  = '{1, 1008, 32'd1};
        tbl[3]  = '{1, 1003, 32'd0};  tbl[4]  = '{1, 1005, 32'd0};  tbl[5]  = '{1, 1007, 32'd0};
        tbl[6]  = '{2, 1006, 32'hFFFFFFFF}; tbl[7] = '{2, 1004, 32'd1}; tbl[8] = '{2, 1008, 32'd1};
        tbl[9]  = '{3, 1006, 32'd1};  tbl[10] = '{3, 1004, 32'd1};  tbl[11] = '{3, 1008, 32'd0};
        tbl[12] = '{4, 1006, 32'd1};  tbl[13] = '{4, 1004, 32'd1};  tbl[14] = '{4, 1008, 32'd1};
        tbl[15] = '{4, 1005, 32'd0};
        for (int k = 0; k < 3; k++) begin
            m_start[k] = 1'b0;
            n_wr[k] = 0; n_bad[k] = 0; n_done[k] = 0;
        end

        pk_clr = 1'b1;
        repeat (2) @(negedge clk);
        pk_clr = 1'b0;
        for (int k = 0; k < 3; k++)
            check($sformatf("reset_outputs_%0d", k),
                  64'({m_busy[k], m_done[k], m_we[k], m_addr[k], m_wd[k]}), 64'd0);

        // dut_a / dut_c graph: node1 -> {2}, node2 -> {1}; dut_b seed 3 has last < first.
        poke(0, 0, 32'd1);   poke(0, 12, 32'd100); poke(0, 13, 32'd100);
        poke(0, 14, 32'd101); poke(0, 15, 32'd101); poke(0, 100, 32'd2); poke(0, 101, 32'd1);
        poke(1, 0, 32'd3);   poke(1, 16, 32'd5);   poke(1, 17, 32'd4);
        poke(2, 0, 32'd1);   poke(2, 1, 32'd2);
        poke(2, 12, 32'd100); poke(2, 13, 32'd100); poke(2, 14, 32'd101); poke(2, 15, 32'd101);
        poke(2, 100, 32'd2); poke(2, 101, 32'd1);

        @(negedge clk);
        arst_n = 1'b1;
        w0 = n_wr[0] + n_wr[1] + n_wr[2];
        hi = 0;
        repeat (100) begin
            @(negedge clk);
            if (m_we[0] || m_we[1] || m_we[2] || m_busy[0] || m_busy[1] || m_busy[2]) hi++;
        end
        check("idle_no_activity", 64'(hi), 64'd0);
        check("idle_no_writes", 64'(n_wr[0] + n_wr[1] + n_wr[2] - w0), 64'd0);

        // Line graph, with a start pulse mid-run that must be ignored.
        w0 = n_wr[0]; d0 = n_done[0];
        run(0, 10, cyc, blo);
        check("line_cycles", 64'(cyc), 64'd36);
        check("line_busy_gaps", 64'(blo), 64'd0);
        check("line_busy_at_done", 64'(m_busy[0]), 64'd0);
        repeat (4) @(negedge clk);
        check("line_idle_after", 64'(m_busy[0]), 64'd0);
        check("line_done_pulses", 64'(n_done[0] - d0), 64'd1);
        check("line_writes", 64'(n_wr[0] - w0), 64'd3);
        check_tbl(1);

        // Saturating counter at the first target.
        clear_counters();
        poke(0, 1006, 32'hFFFFFFFF);
        run(0, 0, cyc, blo);
        check("sat_cycles", 64'(cyc), 64'd36);
        repeat (2) @(negedge clk);
        check_tbl(2);

        // Reset landing on the step-2 counter write of walk 0.
        clear_counters();
        @(negedge clk);
        m_start[0] = 1'b1;
        @(negedge clk);
        m_start[0] = 1'b0;
        cyc = 1;
        while (cyc < 34) begin
            @(negedge clk);
            cyc++;
        end
        check("midrst_we_before", 64'(m_we[0]), 64'd1);
        check("midrst_addr_before", 64'(m_addr[0]), 64'd1008);
        arst_n = 1'b0;
        #1;
        check("midrst_we", 64'(m_we[0]), 64'd0);
        check("midrst_busy", 64'(m_busy[0]), 64'd0);
        check("midrst_addr", 64'(m_addr[0]), 64'd0);
        w0 = n_wr[0];
        repeat (3) @(negedge clk);
        arst_n = 1'b1;
        hi = 0;
        repeat (20) begin
            @(negedge clk);
            if (m_busy[0]) hi++;
        end
        check("midrst_stays_idle", 64'(hi), 64'd0);
        check("midrst_no_writes", 64'(n_wr[0] - w0), 64'd0);
        check_tbl(3);
        clear_counters();
        run(0, 0, cyc, blo);
        check("rerun_cycles", 64'(cyc), 64'd36);
        repeat (2) @(negedge clk);
        check_tbl(4);

        // Dangling seed: every step short-circuits, no counter traffic.
        w0 = n_wr[1]; d0 = n_done[1];
        run(1, 0, cyc, blo);
        check("dangle_cycles", 64'(cyc), 64'd75);
        check("dangle_busy_gaps", 64'(blo), 64'd0);
        check("dangle_busy_at_done", 64'(m_busy[1]), 64'd0);
        repeat (3) @(negedge clk);
        check("dangle_done_pulses", 64'(n_done[1] - d0), 64'd1);
        check("dangle_writes", 64'(n_wr[1] - w0), 64'd0);

        // Threshold at maximum: every step restarts.
        w0 = n_wr[2]; d0 = n_done[2];
        run(2, 0, cyc, blo);
        check("restart_cycles", 64'(cyc), 64'd77);
        check("restart_busy_gaps", 64'(blo), 64'd0);
        repeat (3) @(negedge clk);
        check("restart_done_pulses", 64'(n_done[2] - d0), 64'd1);
        check("restart_writes", 64'(n_wr[2] - w0), 64'd0);

        check("wdata_zero_when_not_writing", 64'(n_bad[0] + n_bad[1] + n_bad[2]), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ppr_walk_engine.md
PPR_WALK_ENGINE -- requirements
Module: ppr_walk_engine

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
  ADDR_WIDTH, 13, BRAM address width.
  DATA_WIDTH, 32, BRAM data width.
  SEED_NUM, 10, number of seeds; seed node IDs are stored at addresses 0..SEED_NUM-1.
  M_RW, 100, walks per seed.
  MAX_STEPS, 6, steps per walk.
  NEI_ADDR_OFF, 10, base of the first/last-neighbour address table (2 words per node).
  CNT_OFF, 1000, base of the counter table.
  RESTART_THR, 16'h0000, restart threshold; a restart occurs when LFSR[31:16] < RESTART_THR (0 disables restart).
  LFSR_INIT, 32'h00000007, LFSR reset value.
REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
  clk  in  1  sole clock; all state updates on posedge.
  arst_n  in  1  asynchronous active-low reset.
  start  in  1  one-cycle request to begin a full run.
  busy  out  1  high from the cycle after an accepted start until done.
  done  out  1  one-cycle pulse when the run completes.
  mem_addr  out  ADDR_WIDTH  BRAM address.
  mem_we  out  1  BRAM write enable.
  mem_wdata  out  DATA_WIDTH  BRAM write data.
  mem_rdata  in  DATA_WIDTH  BRAM read data, valid exactly 1 cycle after its address is presented.
REQ-003 The design SHALL use one clock; reset SHALL be asynchronous and active-low. No internally divided clocks.

Function
REQ-004 The FSM states SHALL be IDLE, RD_SEED, RD_FIRST, RD_LAST, CHK, RD_NEI, RD_CNT, WR_CNT, ADV, DONE.
REQ-005 Each RD_* state SHALL take 2 cycles: an issue cycle (address driven, mem_we=0), then a capture cycle (mem_rdata registered).
REQ-006 In IDLE, start=1 SHALL clear seed_idx, walk_idx and step_idx and go to RD_SEED; start while busy SHALL be ignored.
REQ-007 RD_SEED SHALL read address seed_idx into seed_node, set curr=seed_node and go to RD_FIRST.
REQ-008 RD_FIRST/RD_LAST SHALL read addresses NEI_ADDR_OFF+2*curr and NEI_ADDR_OFF+2*curr+1 into first/last.
REQ-009 CHK (1 cycle) SHALL select, in priority order:
  restart hit -> curr=seed_node, go to ADV, no counter update;
  last<first (dangling node) -> same as restart;
  otherwise -> RD_NEI.
REQ-010 RD_NEI SHALL read address first + (lfsr % (last-first+1)) into curr, then go to RD_CNT.
REQ-011 The counter address SHALL be CNT_OFF + (curr*SEED_NUM + seed_idx)*MAX_STEPS + step_idx, truncated to ADDR_WIDTH.
REQ-012 RD_CNT SHALL read the counter at that address. WR_CNT (1 cycle) SHALL drive mem_we=1, the same address, and mem_wdata=counter+1, saturating at all-ones.
REQ-013 ADV (1 cycle) SHALL advance the nested loops:
  step_idx+1 < MAX_STEPS -> step_idx++, go to RD_FIRST;
  else walk_idx+1 < M_RW -> walk_idx++, step_idx=0, curr=seed_node, go to RD_FIRST;
  else seed_idx+1 < SEED_NUM -> seed_idx++, clear walk_idx and step_idx, go to RD_SEED;
  else -> DONE.
REQ-014 DONE SHALL assert done=1 for exactly one cycle and return to IDLE; busy SHALL be 0 in that cycle.
REQ-015 The LFSR SHALL be a 32-bit maximal-length Galois LFSR (taps 32,22,2,1) that advances every cycle regardless of state.
REQ-016 The non-restart step length SHALL be exactly 11 cycles; the restart/dangling step length SHALL be 6 cycles.
REQ-017 mem_we SHALL be 1 only in WR_CNT; in all other states mem_wdata SHALL be held at 0.

Reset
REQ-018 arst_n=0 SHALL immediately force state=IDLE, busy=0, done=0, mem_we=0, mem_addr=0, mem_wdata=0, all indices 0, and lfsr=LFSR_INIT.
REQ-019 A reset mid-run SHALL abandon the run with no further writes; a new start is required after release.

Verification
REQ-020 Reset idle: hold arst_n=0, pulse clk -> all outputs 0; release with no start -> mem_we stays 0 for 100 cycles.
REQ-021 Line graph, SEED_NUM=1, M_RW=1, MAX_STEPS=3, RESTART_THR=0, node 1 neighbour list {2}, node 2 neighbour list {1}, seed=1 -> counters at steps 0,1,2 read 1 for nodes 2,1,2 respectively; done after 2+3*11+1 cycles.
REQ-022 Dangling seed (last<first), M_RW=4 -> zero writes; done pulses once; busy is high for the whole run.
REQ-023 Counter preloaded to 32'hFFFFFFFF at the first target -> written value remains 32'hFFFFFFFF.
REQ-024 RESTART_THR=16'hFFFF -> every step restarts, no writes occur, total run = SEED_NUM*(2+M_RW*MAX_STEPS*6)+1 cycles.
REQ-025 arst_n pulsed low at step 2 of walk 0 -> mem_we=0 in the same cycle; start re-pulsed -> results match an uninterrupted run.
